mem_ctrl_sram: RTL and testbench

- Memory controller: the responder end of the MEM-stage memory-controller interface.
- Accepts 32-bit word read/write requests (rw, en, 18-bit word address, bidirectional 32-bit data).
- Executes each request as two 16-bit accesses on an external asynchronous 256Kx16 SRAM.
- Returns read data on the shared data bus and raises a one-cycle ready pulse for pipeline stall logic.

---
 rtl/mc_pkg.sv | 26 ++
 rtl/mem_ctrl_sram_wait_cnt.sv | 27 ++
 rtl/mem_ctrl_sram.sv | 155 +++++++++++++++
 tb/tb_mem_ctrl_sram.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mc_pkg;

  localparam int MC_AW   = 18;
  localparam int MC_DW   = 32;
  localparam int SRAM_DW = 16;
  localparam int WAIT_CW = 3;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } mc_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_CTRL_IDLE = 5'b11111;

endpackage

// File: rtl/mem_ctrl_sram_wait_cnt.sv
// Loadable down-counter: o_done marks the last cycle of a 1+WAIT_STATES cycle phase.
module mc_wait_cnt
  import mc_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  output logic o_done
);

  logic [WAIT_CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= WAIT_CW'(WAIT_STATES);
    end else if (i_load) begin
      r_cnt <= WAIT_CW'(WAIT_STATES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mem_ctrl_sram.sv
// 32-bit request responder executing each word as two halfword accesses on an async SRAM.
// Define MC_READ_BYPASS_EN to add a one-entry buffer that serves repeat reads without SRAM activity.
module mem_ctrl_sram
  import mc_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int SRAM_AW     = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mc_rw,
  input  logic               mc_en,
  input  logic [MC_AW-1:0]   mc_addr,
  inout  wire  [MC_DW-1:0]   mc_data,
  output logic               mc_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int TW = SRAM_AW - 1;

  mc_state_t          r_state, w_state_next;
  logic [TW-1:0]      r_addr;
  logic               r_rw, r_served, r_gap;
  logic [MC_DW-1:0]   r_wdata, r_rdata;
  logic               w_accept, w_hit, w_counting, w_cnt_done, w_last, w_same_req;
  logic [MC_DW-1:0]   w_byp_data;
  sram_ctrl_t         w_ctrl;
  logic               w_dq_oe;
  logic [SRAM_DW-1:0] w_dq_out;
  logic [SRAM_AW-1:0] w_sram_addr;
  logic               w_unused_addr_msb;

  assign w_unused_addr_msb = mc_addr[MC_AW-1];
  assign w_same_req = (mc_addr[TW-1:0] == r_addr) && (mc_rw == r_rw);

  // The write gap cycle in HI does not count towards the phase length.
  assign w_counting = (r_state == LO) || ((r_state == HI) && !r_gap);
  assign w_last     = w_counting && w_cnt_done;

  mc_wait_cnt #(.WAIT_STATES(WAIT_STATES)) u_wait_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_load (!w_counting || w_cnt_done),
    .o_done (w_cnt_done)
  );

`ifdef MC_READ_BYPASS_EN
  logic          r_byp_valid;
  logic [TW-1:0] r_byp_tag;
  logic [MC_DW-1:0] r_byp_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byp_valid <= 1'b0;
      r_byp_tag   <= '0;
      r_byp_data  <= '0;
    end else if (r_state == DONE) begin
      r_byp_valid <= 1'b1;
      r_byp_tag   <= r_addr;
      r_byp_data  <= r_rw ? r_wdata : r_rdata;
    end
  end

  assign w_hit      = r_byp_valid && !mc_rw && (r_byp_tag == mc_addr[TW-1:0]);
  assign w_byp_data = r_byp_data;
`else
  assign w_hit      = 1'b0;
  assign w_byp_data = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_served <= 1'b0;
      r_gap    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= (r_state == LO) && w_last && r_rw;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_addr <= mc_addr[TW-1:0];
          r_rw   <= mc_rw;
          if (mc_rw) r_wdata <= mc_data;
          if (w_hit) r_rdata <= w_byp_data;
        end else if (!mc_en || !w_same_req) begin
          r_served <= 1'b0;
        end
      end
      if (w_last && !r_rw) begin
        if (r_state == LO) r_rdata[SRAM_DW-1:0] <= sram_dq;
        else               r_rdata[MC_DW-1:SRAM_DW] <= sram_dq;
      end
      if (r_state == DONE) r_served <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ctrl       = SRAM_CTRL_IDLE;
    w_sram_addr  = '0;
    w_dq_oe      = 1'b0;
    w_dq_out     = r_wdata[SRAM_DW-1:0];
    case (r_state)
      IDLE: begin
        if (mc_en && !r_served) begin
          w_accept     = 1'b1;
          w_state_next = w_hit ? DONE : LO;
        end
      end
      LO: begin
        if (w_last) w_state_next = HI;
      end
      HI: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if ((r_state == LO) || (r_state == HI)) begin
      w_ctrl.ce_n = 1'b0;
      w_ctrl.ub_n = 1'b0;
      w_ctrl.lb_n = 1'b0;
      w_sram_addr = {r_addr, (r_state == HI)};
      if (r_rw) begin
        w_dq_oe     = 1'b1;
        w_ctrl.we_n = r_gap;
        if (r_state == HI) w_dq_out = r_wdata[MC_DW-1:SRAM_DW];
      end else begin
        w_ctrl.oe_n = 1'b0;
      end
    end
  end

  assign mc_ready  = (r_state == DONE);
  assign sram_addr = w_sram_addr;
  assign sram_ce_n = w_ctrl.ce_n;
  assign sram_oe_n = w_ctrl.oe_n;
  assign sram_we_n = w_ctrl.we_n;
  assign sram_ub_n = w_ctrl.ub_n;
  assign sram_lb_n = w_ctrl.lb_n;
  assign sram_dq   = w_dq_oe ? w_dq_out : 'z;
  assign mc_data   = (mc_en && !mc_rw) ? r_rdata : 'z;

endmodule

// File: tb/tb_mem_ctrl_sram.sv
// Bench for mem_ctrl_sram: two instances (WAIT_STATES 0 and 2) share random stimulus and are
// checked every cycle against a cycle-count model of the request timeline and word memory.
module tb_mem_ctrl_sram;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mc_rw = 1'b0;
  logic        mc_en = 1'b0;
  logic [17:0] mc_addr = '0;
  logic [31:0] wdata = '0;

  int vectors = 0;
  int miscompares = 0;

  int lat0, lat1, ce_d0, ce_d1, oe_d0, oe_d1;
  logic [31:0] rd0, rd1;

  initial forever #5 clock = ~clock;

  function automatic logic [15:0] hw_init(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 0 : 2;

    wire [31:0] mc_data;
    wire        mc_ready;
    wire [17:0] sram_addr;
    wire [15:0] sram_dq;
    wire        ce_n, oe_n, we_n, ub_n, lb_n;

    logic [15:0] sram_mem [0:(1<<18)-1];
    int ce_cnt = 0;
    int oe_cnt = 0;

    assign mc_data = (mc_en && mc_rw) ? wdata : 32'hz;
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'hz;

    mem_ctrl_sram #(.WAIT_STATES(W), .SRAM_AW(18)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .mc_rw     (mc_rw),
      .mc_en     (mc_en),
      .mc_addr   (mc_addr),
      .mc_data   (mc_data),
      .mc_ready  (mc_ready),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .sram_ce_n (ce_n),
      .sram_oe_n (oe_n),
      .sram_we_n (we_n),
      .sram_ub_n (ub_n),
      .sram_lb_n (lb_n)
    );

    initial begin
      for (int a = 0; a < (1 << 18); a++) sram_mem[a] = hw_init(18'(a));
    end

    always @(negedge clock) begin
      if (!ce_n && !we_n) sram_mem[sram_addr] = sram_dq;
      if (!ce_n) ce_cnt = ce_cnt + 1;
      if (!ce_n && !oe_n) oe_cnt = oe_cnt + 1;
    end

    // Model: an accepted request occupies cycles k=1..R, ready on k==R.
    bit          m_busy, m_served, m_rw, m_hit;
    int          m_k, m_R;
    logic [16:0] m_addr;
    logic [31:0] m_wd, m_pend, m_rdata;
    logic [31:0] m_mem [logic [16:0]];
    bit          b_valid;
    logic [16:0] b_tag;
    logic [31:0] b_data;

    always @(posedge clock or negedge reset) begin
      if (!reset) begin
        m_busy = 0; m_served = 0; m_rw = 0; m_hit = 0;
        m_k = 0; m_R = 0; m_addr = '0; m_rdata = '0; b_valid = 0;
      end else if (m_busy) begin
        if (m_k == m_R) begin
          m_busy = 0;
          m_served = 1;
          if (!m_rw) m_rdata = m_pend;
          b_valid = 1;
          b_tag = m_addr;
          b_data = m_rw ? m_wd : m_pend;
        end else begin
          m_k++;
        end
      end else if (mc_en && !m_served) begin
        m_busy = 1; m_k = 1; m_hit = 0;
        m_rw = mc_rw;
        m_addr = mc_addr[16:0];
        if (mc_rw) begin
          m_wd = wdata;
          m_mem[m_addr] = wdata;
          m_R = 2 * (1 + W) + 2;
        end else begin
          m_R = 2 * (1 + W) + 1;
          m_pend = m_mem.exists(m_addr) ? m_mem[m_addr]
                                        : {hw_init({m_addr, 1'b1}), hw_init({m_addr, 1'b0})};
`ifdef MC_READ_BYPASS_EN
          if (b_valid && b_tag == m_addr) begin
            m_hit = 1; m_R = 1; m_pend = b_data;
          end
`endif
        end
      end else if (!mc_en || mc_addr[16:0] != m_addr || mc_rw != m_rw) begin
        m_served = 0;
      end
    end

    logic [4:0]  e_ctrl;
    logic [17:0] e_addr;
    bit          act_ph;

    always @(negedge clock) begin
      act_ph = m_busy && (m_k < m_R) && !m_hit;
      e_ctrl = 5'b11111;
      e_addr = '0;
      chk(gi, "ready", {31'd0, mc_ready}, {31'd0, m_busy && (m_k == m_R)});
      if (act_ph) begin
        e_addr = {m_addr, (m_k > 1 + W)};
        if (m_rw) begin
          e_ctrl = {1'b0, 1'b1, (m_k == 2 + W), 2'b00};
          chk(gi, "sram_dq", {16'd0, sram_dq}, {16'd0, (m_k <= 1 + W) ? m_wd[15:0] : m_wd[31:16]});
        end else begin
          e_ctrl = 5'b00100;
        end
      end
      chk(gi, "ctrl_ce_oe_we_ub_lb", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, {27'd0, e_ctrl});
      chk(gi, "sram_addr", {14'd0, sram_addr}, {14'd0, e_addr});
      if (mc_en && !mc_rw && (!m_busy || m_k == m_R))
        chk(gi, "mc_data", mc_data, (m_busy && !m_rw) ? m_pend : m_rdata);
    end
  end

  task automatic issue(input bit rw, input logic [17:0] a, input logic [31:0] d);
    int s0, s1, o0, o1;
    mc_en = 1'b0;
    for (int i = 0; i < 40 && (g_inst[0].m_busy || g_inst[1].m_busy); i++) step();
    chk(0, "settle", {30'd0, g_inst[0].m_busy, g_inst[1].m_busy}, 32'd0);
    step();
    s0 = g_inst[0].ce_cnt; s1 = g_inst[1].ce_cnt;
    o0 = g_inst[0].oe_cnt; o1 = g_inst[1].oe_cnt;
    mc_en = 1'b1; mc_rw = rw; mc_addr = a; wdata = d;
    lat0 = -1; lat1 = -1; rd0 = '0; rd1 = '0;
    for (int c = 1; c <= 40 && (lat0 < 0 || lat1 < 0); c++) begin
      @(negedge clock);
      if (lat0 < 0 && g_inst[0].mc_ready) begin lat0 = c; rd0 = g_inst[0].mc_data; end
      if (lat1 < 0 && g_inst[1].mc_ready) begin lat1 = c; rd1 = g_inst[1].mc_data; end
    end
    #1;
    mc_en = 1'b0;
    ce_d0 = g_inst[0].ce_cnt - s0; ce_d1 = g_inst[1].ce_cnt - s1;
    oe_d0 = g_inst[0].oe_cnt - o0; oe_d1 = g_inst[1].oe_cnt - o1;
    $display("txn %s addr=%05h data=%08h lat=%0d/%0d rdata=%08h/%08h", rw ? "WR" : "RD", a, d, lat0, lat1, rd0, rd1);
  endtask

  int exp_rl0, exp_rl1, exp_rce0, exp_rce1, s0, s1, hold;

  initial begin
`ifdef MC_READ_BYPASS_EN
    exp_rl0 = 1; exp_rl1 = 1; exp_rce0 = 0; exp_rce1 = 0;
`else
    exp_rl0 = 3; exp_rl1 = 7; exp_rce0 = 2; exp_rce1 = 6;
`endif
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_ctrl", {27'd0, (i == 0) ? g_inst[0].ce_n : g_inst[1].ce_n,
                          (i == 0) ? g_inst[0].we_n : g_inst[1].we_n, 3'b111}, 32'h1F);
    end
    chk(0, "rst_ready", {31'd0, g_inst[0].mc_ready}, 32'd0);
    chk(0, "rst_addr", {14'd0, g_inst[0].sram_addr}, 32'd0);
    #1 reset = 1'b1;
    step();

    issue(1'b1, 18'h00010, 32'hDEADBEEF);
    chk(0, "wr_lat", lat0, 4);
    chk(1, "wr_lat", lat1, 8);
    chk(0, "mem_20", {16'd0, g_inst[0].sram_mem[18'h00020]}, 32'hBEEF);
    chk(0, "mem_21", {16'd0, g_inst[0].sram_mem[18'h00021]}, 32'hDEAD);
    chk(1, "mem_21", {16'd0, g_inst[1].sram_mem[18'h00021]}, 32'hDEAD);

    issue(1'b0, 18'h00010, 32'h0);
    chk(0, "rd_lat", lat0, exp_rl0);
    chk(1, "rd_lat", lat1, exp_rl1);
    chk(0, "rd_data", rd0, 32'hDEADBEEF);
    chk(1, "rd_data", rd1, 32'hDEADBEEF);
    chk(0, "rd_oe_cycles", oe_d0, exp_rce0);

    issue(1'b0, 18'h00005, 32'h0);
    chk(0, "rd5_lat", lat0, 3);
    chk(1, "rd5_lat", lat1, 7);
    chk(1, "rd5_data", rd1, 32'h5A375A36);
    chk(1, "rd5_oe_cycles", oe_d1, 6);

    // Held request: one sequence only, bit 17 ignored; new address starts a second one.
    step();
    s0 = g_inst[0].ce_cnt; s1 = g_inst[1].ce_cnt;
    mc_en = 1'b1; mc_rw = 1'b0; mc_addr = 18'h00010;
    repeat (10) step();
    mc_addr = 18'h20010;
    repeat (10) step();
    chk(0, "hold_ce", g_inst[0].ce_cnt - s0, 2);
    chk(1, "hold_ce", g_inst[1].ce_cnt - s1, 6);
    $display("txn RD hold addr=00010 ce=%0d/%0d", g_inst[0].ce_cnt - s0, g_inst[1].ce_cnt - s1);
    s0 = g_inst[0].ce_cnt; s1 = g_inst[1].ce_cnt;
    mc_addr = 18'h00011;
    repeat (20) step();
    chk(0, "hold2_ce", g_inst[0].ce_cnt - s0, 2);
    chk(1, "hold2_ce", g_inst[1].ce_cnt - s1, 6);
    $display("txn RD hold addr=00011 ce=%0d/%0d", g_inst[0].ce_cnt - s0, g_inst[1].ce_cnt - s1);

    issue(1'b1, 18'h00040, 32'h12345678);
    issue(1'b0, 18'h00040, 32'h0);
    chk(0, "byp_lat", lat0, exp_rl0);
    chk(1, "byp_lat", lat1, exp_rl1);
    chk(0, "byp_ce", ce_d0, exp_rce0);
    chk(0, "byp_data", rd0, 32'h12345678);

    for (int t = 0; t < 250; t++) begin
      mc_en   = ($urandom_range(0, 5) != 0);
      mc_rw   = 1'($urandom_range(0, 1));
      mc_addr = {1'($urandom_range(0, 1)), 17'($urandom_range(0, 15))};
      wdata   = $urandom;
      hold    = $urandom_range(1, 12);
      $display("rnd %0d en=%0b rw=%0b addr=%05h data=%08h hold=%0d", t, mc_en, mc_rw, mc_addr, wdata, hold);
      repeat (hold) step();
    end

    // Asynchronous reset during the HI write pulse of instance 0.
    mc_en = 1'b0;
    for (int i = 0; i < 40 && (g_inst[0].m_busy || g_inst[1].m_busy); i++) step();
    step();
    mc_en = 1'b1; mc_rw = 1'b1; mc_addr = 18'h00100; wdata = 32'hA5A51234;
    repeat (3) @(negedge clock);
    chk(0, "pre_rst_we", {31'd0, g_inst[0].we_n}, 32'd0);
    chk(0, "pre_rst_addr", {14'd0, g_inst[0].sram_addr}, 32'h00201);
    #1 reset = 1'b0;
    mc_en = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "arst_ctrl", (i == 0) ? {27'd0, g_inst[0].ce_n, g_inst[0].oe_n, g_inst[0].we_n, g_inst[0].ub_n, g_inst[0].lb_n}
                                   : {27'd0, g_inst[1].ce_n, g_inst[1].oe_n, g_inst[1].we_n, g_inst[1].ub_n, g_inst[1].lb_n}, 32'h1F);
      chk(i, "arst_ready", {31'd0, (i == 0) ? g_inst[0].mc_ready : g_inst[1].mc_ready}, 32'd0);
      chk(i, "arst_addr", {14'd0, (i == 0) ? g_inst[0].sram_addr : g_inst[1].sram_addr}, 32'd0);
    end
    $display("txn WR addr=00100 aborted by reset");
    repeat (2) step();
    reset = 1'b1;
    step();
    issue(1'b1, 18'h00100, 32'hCAFEF00D);
    issue(1'b0, 18'h00100, 32'h0);
    chk(0, "post_rst_data", rd0, 32'hCAFEF00D);
    chk(1, "post_rst_data", rd1, 32'hCAFEF00D);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
